// File: rtl/tick_gen_bank.sv
// Bank of independent programmable clock dividers with shadowed, glitch-free
// retuning, a global phase-restart strobe and per-channel toggle/pulse outputs.

module tick_gen_ch #(
   parameter int unsigned DIVW    = 20,
   parameter int unsigned DEF_DIV = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_we,
   input  logic [DIVW-1:0] i_div,
   input  logic            i_mode,
   input  logic            i_en,
   input  logic            i_sync,
   output logic            o_out,
   output logic            o_tick,
   output logic            o_pend
);

   typedef enum logic {
      MODE_TOGGLE = 1'b0,
      MODE_PULSE  = 1'b1
   } mode_e;

   logic [DIVW-1:0] r_cnt;
   logic [DIVW-1:0] r_div;
   logic [DIVW-1:0] r_pdiv;
   mode_e           r_mode;
   mode_e           r_pmode;
   logic            r_en;
   logic            r_out;
   logic            r_tick;
   logic            r_pend;
   logic            w_event;

   assign w_event = (r_cnt == r_div);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_div   <= DIVW'(DEF_DIV);
         r_mode  <= MODE_TOGGLE;
         r_en    <= 1'b1;
         r_out   <= 1'b0;
         r_tick  <= 1'b0;
         r_pdiv  <= '0;
         r_pmode <= MODE_TOGGLE;
         r_pend  <= 1'b0;
      end else if (i_we && !i_en) begin
         r_en   <= 1'b0;
         r_cnt  <= '0;
         r_out  <= 1'b0;
         r_tick <= 1'b0;
         r_pend <= 1'b0;
      end else if (!r_en) begin
         r_tick <= 1'b0;
         if (i_we) begin
            r_div  <= i_div;
            r_mode <= mode_e'(i_mode);
            r_en   <= 1'b1;
            r_cnt  <= '0;
            r_out  <= 1'b0;
         end
      end else if (i_sync) begin
         // Restart phase; a same-cycle write takes priority over any older shadow.
         r_cnt  <= '0;
         r_out  <= 1'b0;
         r_tick <= 1'b0;
         r_pend <= 1'b0;
         if (i_we) begin
            r_div  <= i_div;
            r_mode <= mode_e'(i_mode);
         end else if (r_pend) begin
            r_div  <= r_pdiv;
            r_mode <= r_pmode;
         end
      end else begin
         if (w_event) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
            if (r_pend) begin
               r_div  <= r_pdiv;
               r_mode <= r_pmode;
               r_out  <= 1'b0;
               r_pend <= 1'b0;
            end else if (r_mode == MODE_PULSE) begin
               r_out <= 1'b1;
            end else begin
               r_out <= ~r_out;
            end
         end else begin
            r_cnt  <= r_cnt + DIVW'(1);
            r_tick <= 1'b0;
            if (r_mode == MODE_PULSE) r_out <= 1'b0;
         end
         // A write landing on the apply edge re-arms the shadow after it is consumed.
         if (i_we) begin
            r_pdiv  <= i_div;
            r_pmode <= mode_e'(i_mode);
            r_pend  <= 1'b1;
         end
      end
   end

   assign o_out  = r_out;
   assign o_tick = r_tick;
   assign o_pend = r_pend;

endmodule

module tick_gen_bank #(
   parameter int unsigned NCH     = 4,
   parameter int unsigned DIVW    = 20,
   parameter int unsigned DEF_DIV = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            cfg_we,
   input  logic [3:0]      cfg_ch,
   input  logic [DIVW-1:0] cfg_div,
   input  logic            cfg_mode,
   input  logic            cfg_en,
   input  logic            sync,
   output logic [NCH-1:0]  clk_out,
   output logic [NCH-1:0]  tick,
   output logic [NCH-1:0]  pend
);

   logic [NCH-1:0] w_we_hit;

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      // Indices at or above NCH match no channel, so such writes vanish.
      assign w_we_hit[g] = cfg_we && (cfg_ch == 4'(g));

      tick_gen_ch #(
         .DIVW    (DIVW),
         .DEF_DIV (DEF_DIV)
      ) u_ch (
         .clk    (clk),
         .rst_n  (rst_n),
         .i_we   (w_we_hit[g]),
         .i_div  (cfg_div),
         .i_mode (cfg_mode),
         .i_en   (cfg_en),
         .i_sync (sync),
         .o_out  (clk_out[g]),
         .o_tick (tick[g]),
         .o_pend (pend[g])
      );
   end

endmodule
